// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store unit bridging the M stage to a word-wide ready/valid memory bus
// Ports: clk/rst (async active-high); ALU_outM_i byte address, WriteDataM_i store data,
// MemWriteM_i/ResultSrcM_i store/load request, ByteSelectM_i size, MemExtendM_i sign-extend;
// StallM_o pipeline hold, ReadDataM_o/ReadValidM_o load result, MisalignM_o, BusErrM_o timeout pulse;
// mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_wstrb_o bus request, mem_ready_i/mem_rdata_i completion.
module memory_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_outM_i,
  input  logic [31:0] WriteDataM_i,
  input  logic        MemWriteM_i,
  input  logic        ResultSrcM_i,
  input  logic [1:0]  ByteSelectM_i,
  input  logic        MemExtendM_i,
  output logic        StallM_o,
  output logic [31:0] ReadDataM_o,
  output logic        ReadValidM_o,
  output logic        MisalignM_o,
  output logic        BusErrM_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  off_q, off_d, size_q, size_d;
  logic [7:0]  wd_q, wd_d;
  logic        we_q, we_d, ext_q, ext_d, bus_err_q, bus_err_d;
  logic        access, misalign, issue, expire;
  logic [31:0] shifted, load_val, wdata_n;
  logic [3:0]  wstrb_n;
  always_comb begin
    access   = MemWriteM_i | ResultSrcM_i;
    misalign = (ByteSelectM_i == 2'b01 & ALU_outM_i[0]) | (ByteSelectM_i[1] & |ALU_outM_i[1:0]);
    issue    = state_q == IDLE & access & ~misalign;
    // watchdog sits at 254 during the 255th waiting cycle; ready in that cycle still wins
    expire   = state_q == REQ & ~mem_ready_i & wd_q == 8'd254;
    wstrb_n  = ByteSelectM_i == 2'b00 ? 4'b0001 << ALU_outM_i[1:0] :
               ByteSelectM_i == 2'b01 ? 4'b0011 << ALU_outM_i[1:0] : 4'b1111;
    wdata_n  = ByteSelectM_i == 2'b00 ? {4{WriteDataM_i[7:0]}} :
               ByteSelectM_i == 2'b01 ? {2{WriteDataM_i[15:0]}} : WriteDataM_i;
    shifted  = mem_rdata_i >> {off_q, 3'b000};
    load_val = size_q == 2'b00 ? {{24{ext_q & shifted[7]}}, shifted[7:0]} :
               size_q == 2'b01 ? {{16{ext_q & shifted[15]}}, shifted[15:0]} : shifted;
    state_d  = issue ? REQ :
               state_q == REQ & mem_ready_i ? DONE :
               expire | state_q == DONE ? IDLE : state_q;
    addr_d    = issue ? {ALU_outM_i[31:2], 2'b00} : addr_q;
    wdata_d   = issue ? wdata_n : wdata_q;
    wstrb_d   = issue ? wstrb_n : wstrb_q;
    we_d      = issue ? MemWriteM_i : we_q;
    off_d     = issue ? ALU_outM_i[1:0] : off_q;
    size_d    = issue ? ByteSelectM_i : size_q;
    ext_d     = issue ? MemExtendM_i : ext_q;
    wd_d      = issue ? 8'd0 : state_q == REQ & ~mem_ready_i ? wd_q + 8'd1 : wd_q;
    rdata_d   = state_q == REQ & mem_ready_i & ~we_q ? load_val : rdata_q;
    bus_err_d = expire;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      ext_q     <= 1'b0;
      wd_q      <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      off_q     <= off_d;
      size_q    <= size_d;
      ext_q     <= ext_d;
      wd_q      <= wd_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  assign StallM_o     = issue | state_q == REQ;
  assign MisalignM_o  = state_q == IDLE & access & misalign;
  assign ReadValidM_o = state_q == DONE & ~we_q;
  assign ReadDataM_o  = rdata_q;
  assign BusErrM_o    = bus_err_q;
  assign mem_req_o    = state_q == REQ;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wstrb_o  = wstrb_q;
endmodule
